// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants and hazard-controller state type.
// Imported by the opcode decoder and by pipeline_hazard_ctrl.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] U_TYPE = 7'b0110111;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] HALT   = 7'b0000000;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_DRAIN, S_HALTED} hz_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      R_TYPE, I_TYPE, LW, SW, BR, JALR: uses_rs1 = 1'b1;
      default:                          uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      R_TYPE, SW, BR: uses_rs2 = 1'b1;
      default:        uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequences the 5-stage pipeline: load-use stalls, redirect flushes, memory-wait freezes and
// HALT drain, with saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  hz_state_e     state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          lu_q, lu_d;
  logic          hazard;
  logic          stall_inc, flush_inc;

  assign hazard = ex_memread && (ex_rd != 5'd0) &&
                  (((ex_rd == id_rs1) && uses_rs1(id_opcode)) ||
                   ((ex_rd == id_rs2) && uses_rs2(id_opcode)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    lu_d         = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      S_RESET: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        {ifid_flush, idex_bubble, memwb_bubble}         = 3'b111;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mem_busy) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
          // The bubble already in EX stays put, so the one-shot guard must survive the freeze.
          lu_d = lu_q;
        end else if (ex_redirect) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (id_opcode == HALT) begin
          {pc_write, ifid_write} = 2'b00;
          idex_bubble = 1'b1;
          drain_d     = DRAIN_INIT;
          state_d     = S_DRAIN;
        end else if (hazard && !lu_q) begin
          {pc_write, ifid_write} = 2'b00;
          idex_bubble = 1'b1;
          lu_d        = 1'b1;
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          memwb_bubble = 1'b1;
        end else begin
          {pc_write, ifid_write} = 2'b00;
          idex_bubble = 1'b1;
          if (drain_q != '0) drain_d = drain_q - DW'(1);
          if (drain_q <= DW'(1)) state_d = S_HALTED;
        end
      end
      default: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
        {idex_bubble, memwb_bubble, halted}             = 3'b111;
      end
    endcase
  end

  assign stall_inc = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !pc_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      drain_q <= '0;
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      lu_q    <= lu_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed scenarios plus random traffic, checked against a behavioural
// model of the pipeline sequencing rules.
module tb_pipeline_hazard_ctrl;
  import riscv_pkg::*;

  localparam int CW = 4;
  localparam int DC = 3;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    id_opcode = U_TYPE;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          ex_memread = 1'b0, ex_redirect = 1'b0, mem_busy = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic          exmem_write, memwb_bubble, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  // ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
  //         memwb_bubble, halted}
  typedef struct {
    logic [7:0]    ctrl;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Model: mode 0 boot, 1 running, 2 draining, 3 halted.
  int mode = 0;
  int drain_left = 0;
  bit bubble_in_ex = 0;  // previous issued cycle already inserted a load-use bubble
  int n_stall = 0;
  int n_flush = 0;

  task automatic step(input logic rst, input logic [6:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic mr, input logic [4:0] rd,
                      input logic rdr, input logic busy);
    exp_t e;
    bit   stalled;
    bit   hz;
    @(posedge clk);
    #1;
    reset = rst; id_opcode = op; id_rs1 = r1; id_rs2 = r2;
    ex_memread = mr; ex_rd = rd; ex_redirect = rdr; mem_busy = busy;
    if (rst) begin
      mode = 0; drain_left = 0; bubble_in_ex = 0; n_stall = 0; n_flush = 0;
    end
    e.stall = CW'(n_stall);
    e.flush = CW'(n_flush);
    stalled = 0;
    hz = mr && rd != 0 &&
         ((rd == r1 && (op inside {R_TYPE, I_TYPE, LW, SW, BR, JALR})) ||
          (rd == r2 && (op inside {R_TYPE, SW, BR})));
    case (mode)
      0: begin
        e.ctrl = 8'b0010_1010;
        if (!rst) mode = 1;
      end
      1: begin
        if (busy) begin
          e.ctrl = 8'b0000_0010; stalled = 1;
        end else if (rdr) begin
          e.ctrl = 8'b1111_1100; n_flush = (n_flush < SAT) ? n_flush + 1 : SAT;
          bubble_in_ex = 0;
        end else if (op == HALT) begin
          e.ctrl = 8'b0001_1100; stalled = 1; drain_left = DC - 1; mode = 2;
          bubble_in_ex = 0;
        end else if (hz && !bubble_in_ex) begin
          e.ctrl = 8'b0001_1100; stalled = 1; bubble_in_ex = 1;
        end else begin
          e.ctrl = 8'b1101_0100; bubble_in_ex = 0;
        end
      end
      2: begin
        stalled = 1;
        if (busy) e.ctrl = 8'b0000_0010;
        else begin
          e.ctrl = 8'b0001_1100;
          drain_left--;
          if (drain_left <= 0) mode = 3;
        end
      end
      default: e.ctrl = 8'b0000_1011;
    endcase
    if (stalled) n_stall = (n_stall < SAT) ? n_stall + 1 : SAT;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, U_TYPE, 5'd0, 5'd0, 0, 5'd0, 0, 0);
  endtask

  exp_t                       got;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checks += 3;
      if ({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           memwb_bubble, halted} !== got.ctrl) begin
        failures++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, {pc_write, ifid_write, ifid_flush,
                 idex_write, idex_bubble, exmem_write, memwb_bubble, halted}, got.ctrl);
      end
      if (stall_cnt !== got.stall) begin
        failures++;
        $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, got.stall);
      end
      if (flush_cnt !== got.flush) begin
        failures++;
        $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, flush_cnt, got.flush);
      end
    end
  end

  initial begin
    int halt_age;
    // Reset release and first running cycles
    step(1, U_TYPE, 0, 0, 0, 0, 0, 0);
    step(1, U_TYPE, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID held for two cycles -> one stall
    step(0, R_TYPE, 5'd5, 5'd1, 1, 5'd5, 0, 0);
    step(0, R_TYPE, 5'd5, 5'd1, 1, 5'd5, 0, 0);
    step(0, R_TYPE, 5'd0, 5'd0, 1, 5'd0, 0, 0);   // ex_rd = x0
    step(0, U_TYPE, 5'd5, 5'd5, 1, 5'd5, 0, 0);   // LUI never stalls
    step(0, SW, 5'd1, 5'd7, 1, 5'd7, 0, 0);       // rs2 hazard
    // Redirect beats HALT in ID
    step(0, HALT, 0, 0, 0, 0, 1, 0);
    idle(1);
    // Busy beats redirect, then the redirect acts
    step(0, R_TYPE, 0, 0, 0, 0, 1, 1);
    step(0, R_TYPE, 0, 0, 0, 0, 1, 0);
    // HALT with two busy cycles mid-drain, then stay halted
    step(0, HALT, 0, 0, 0, 0, 0, 0);
    step(0, U_TYPE, 0, 0, 0, 0, 1, 0);
    step(0, U_TYPE, 0, 0, 0, 0, 0, 1);
    step(0, U_TYPE, 0, 0, 0, 0, 0, 1);
    step(0, U_TYPE, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Counter saturation: 20 separate load-use stalls
    step(1, U_TYPE, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, LW, 5'd3, 5'd0, 1, 5'd3, 0, 0);
      step(0, LW, 5'd3, 5'd0, 0, 5'd3, 0, 0);
    end
    // Reset in the middle of a drain
    step(0, HALT, 0, 0, 0, 0, 0, 0);
    step(0, U_TYPE, 0, 0, 0, 0, 0, 0);
    step(1, U_TYPE, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Random traffic
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] op;
      int         k;
      k = $urandom_range(0, 19);
      case (k % 8)
        0: op = R_TYPE; 1: op = I_TYPE; 2: op = U_TYPE; 3: op = LW;
        4: op = SW;     5: op = BR;     6: op = JAL;    default: op = JALR;
      endcase
      if (k == 0) op = HALT;
      halt_age = (mode == 3) ? halt_age + 1 : 0;
      step(($urandom_range(0, 99) == 0) || (halt_age > 4), op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20);
    end
    idle(2);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
